// File: rtl/pkt_pkg.sv
// Shared symbol constants, CRC helpers and receiver state encoding for the
// 10-bit packet receive path.
package pkt_pkg;

   localparam logic [8:0]  K28_1      = 9'h13C;
   localparam logic [8:0]  K28_5      = 9'h1BC;
   localparam logic [8:0]  K23_7      = 9'h1F7;

   localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_SYNC,
      ST_PAYLOAD,
      ST_CRCB,
      ST_WAIT_EOP
   } rx_state_t;

   // Reflected CRC-32 step, data consumed LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                              input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int unsigned i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      return c;
   endfunction

endpackage

// File: rtl/dec_10b8b.sv
// Combinational 8b/10b decoder: 5b/6b and 3b/4b table lookup plus running
// disparity check; symbol bit order abcdei fghj with a in bit 9.
module dec_10b8b (
   input  logic [9:0] symbol,
   input  logic       rd_in,
   output logic       k,
   output logic [7:0] data_byte,
   output logic       code_err,
   output logic       disp_err,
   output logic       rd_out
);

   logic [5:0] s6;
   logic [3:0] s4, s4v;
   logic [4:0] v5;
   logic [2:0] v3, n6, n4;
   logic       ok6, ok4, k28, a7, p7, legal7, rd_mid, bad;

   always_comb begin
      s6  = symbol[9:4];
      s4  = symbol[3:0];
      ok6 = 1'b1;
      k28 = 1'b0;
      v5  = '0;
      unique case (s6)
         6'b100111, 6'b011000: v5 = 5'd0;
         6'b011101, 6'b100010: v5 = 5'd1;
         6'b101101, 6'b010010: v5 = 5'd2;
         6'b110001:            v5 = 5'd3;
         6'b110101, 6'b001010: v5 = 5'd4;
         6'b101001:            v5 = 5'd5;
         6'b011001:            v5 = 5'd6;
         6'b111000, 6'b000111: v5 = 5'd7;
         6'b111001, 6'b000110: v5 = 5'd8;
         6'b100101:            v5 = 5'd9;
         6'b010101:            v5 = 5'd10;
         6'b110100:            v5 = 5'd11;
         6'b001101:            v5 = 5'd12;
         6'b101100:            v5 = 5'd13;
         6'b011100:            v5 = 5'd14;
         6'b010111, 6'b101000: v5 = 5'd15;
         6'b011011, 6'b100100: v5 = 5'd16;
         6'b100011:            v5 = 5'd17;
         6'b010011:            v5 = 5'd18;
         6'b110010:            v5 = 5'd19;
         6'b001011:            v5 = 5'd20;
         6'b101010:            v5 = 5'd21;
         6'b011010:            v5 = 5'd22;
         6'b111010, 6'b000101: v5 = 5'd23;
         6'b110011, 6'b001100: v5 = 5'd24;
         6'b100110:            v5 = 5'd25;
         6'b010110:            v5 = 5'd26;
         6'b110110, 6'b001001: v5 = 5'd27;
         6'b001110:            v5 = 5'd28;
         6'b101110, 6'b010001: v5 = 5'd29;
         6'b011110, 6'b100001: v5 = 5'd30;
         6'b101011, 6'b010100: v5 = 5'd31;
         6'b001111, 6'b110000: begin v5 = 5'd28; k28 = 1'b1; end
         default:              ok6 = 1'b0;
      endcase

      // K.28 in its RD+ form carries the complemented 4b sub-block.
      s4v = (s6 == 6'b110000) ? ~s4 : s4;
      ok4 = 1'b1;
      a7  = 1'b0;
      p7  = 1'b0;
      v3  = '0;
      unique case (s4v)
         4'b1011, 4'b0100: v3 = 3'd0;
         4'b1001:          v3 = 3'd1;
         4'b0101:          v3 = 3'd2;
         4'b1100, 4'b0011: v3 = 3'd3;
         4'b1101, 4'b0010: v3 = 3'd4;
         4'b1010:          v3 = 3'd5;
         4'b0110:          v3 = 3'd6;
         4'b1110, 4'b0001: begin v3 = 3'd7; p7 = 1'b1; end
         4'b0111, 4'b1000: begin v3 = 3'd7; a7 = 1'b1; end
         default:          ok4 = 1'b0;
      endcase

      k      = k28;
      legal7 = 1'b1;
      if (!k28) begin
         if (a7) begin
            if (v5 inside {5'd23, 5'd27, 5'd29, 5'd30})
               k = 1'b1;
            else
               legal7 = (s4 == 4'b0111 && v5 inside {5'd17, 5'd18, 5'd20}) ||
                        (s4 == 4'b1000 && v5 inside {5'd11, 5'd13, 5'd14});
         end else if (p7) begin
            legal7 = !((s4 == 4'b1110 && v5 inside {5'd17, 5'd18, 5'd20}) ||
                       (s4 == 4'b0001 && v5 inside {5'd11, 5'd13, 5'd14}));
         end
      end

      n6     = 3'($countones(s6));
      n4     = 3'($countones(s4));
      bad    = 1'b0;
      rd_mid = rd_in;
      if (n6 == 3'd4) begin
         bad    = rd_in;
         rd_mid = 1'b1;
      end else if (n6 == 3'd2) begin
         bad    = !rd_in;
         rd_mid = 1'b0;
      end else if (s6 == 6'b111000) begin
         bad = rd_in;
      end else if (s6 == 6'b000111) begin
         bad = !rd_in;
      end

      rd_out = rd_mid;
      if (n4 == 3'd3) begin
         bad    = bad | rd_mid;
         rd_out = 1'b1;
      end else if (n4 == 3'd1) begin
         bad    = bad | !rd_mid;
         rd_out = 1'b0;
      end else if (s4 == 4'b1100) begin
         bad = bad | rd_mid;
      end else if (s4 == 4'b0011) begin
         bad = bad | !rd_mid;
      end

      code_err  = !(ok6 && ok4 && legal7);
      disp_err  = !code_err && bad;
      data_byte = {v3, v5};
   end

endmodule

// File: rtl/pkt_rx_10b.sv
// Packet receiver: decodes 8b/10b symbols, frames sync/payload/CRC/EOP and
// checks the IEEE CRC-32 of the payload.
module pkt_rx_10b
   import pkt_pkg::*;
#(
   parameter int MAX_LEN  = 1024,
   parameter int SYNC_CNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pushin,
   input  logic [9:0] datain,
   output logic       pushout,
   output logic [7:0] dataout,
   output logic       startout,
   output logic       eop,
   output logic       crc_ok,
   output logic       frame_err,
   output logic       code_err,
   output logic       disp_err
);

   localparam int CW = $clog2(SYNC_CNT + 1);
   localparam int LW = $clog2(MAX_LEN + 1);

   rx_state_t     state;
   logic          rd;
   logic [CW-1:0] sync_cnt;
   logic [LW-1:0] len;
   logic [1:0]    idx;
   logic [31:0]   crc_reg, rx_crc;

   logic          dk, dec_code_err, dec_disp_err, dec_rd, sync_done;
   logic [7:0]    dbyte;
   logic [8:0]    sym;

   dec_10b8b u_dec (
      .symbol    (datain),
      .rd_in     (rd),
      .k         (dk),
      .data_byte (dbyte),
      .code_err  (dec_code_err),
      .disp_err  (dec_disp_err),
      .rd_out    (dec_rd)
   );

   always_comb begin
      sym       = {dk, dbyte};
      sync_done = (int'(sync_cnt) >= SYNC_CNT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_HUNT;
         rd        <= 1'b0;
         sync_cnt  <= '0;
         len       <= '0;
         idx       <= '0;
         crc_reg   <= CRC32_INIT;
         rx_crc    <= '0;
         pushout   <= 1'b0;
         dataout   <= '0;
         startout  <= 1'b0;
         eop       <= 1'b0;
         crc_ok    <= 1'b0;
         frame_err <= 1'b0;
         code_err  <= 1'b0;
         disp_err  <= 1'b0;
      end else begin
         pushout   <= 1'b0;
         startout  <= 1'b0;
         eop       <= 1'b0;
         crc_ok    <= 1'b0;
         frame_err <= 1'b0;
         code_err  <= 1'b0;
         disp_err  <= 1'b0;
         if (pushin) begin
            if (dec_code_err) begin
               code_err <= 1'b1;
               if (state != ST_HUNT) begin
                  frame_err <= 1'b1;
                  state     <= ST_HUNT;
               end
            end else begin
               disp_err <= dec_disp_err;
               rd       <= dec_rd;
               case (state)
                  ST_HUNT: begin
                     if (sym == K28_1) begin
                        state    <= ST_SYNC;
                        sync_cnt <= CW'(1);
                     end
                  end
                  ST_SYNC: begin
                     if (sym == K28_1) begin
                        if (!sync_done) sync_cnt <= sync_cnt + 1'b1;
                     end else if (!dk && sync_done) begin
                        state    <= ST_PAYLOAD;
                        crc_reg  <= crc32_byte(CRC32_INIT, dbyte);
                        len      <= LW'(1);
                        pushout  <= 1'b1;
                        startout <= 1'b1;
                        dataout  <= dbyte;
                     end else if (sym == K23_7 && sync_done) begin
                        // Empty payload: trailer follows the sync run directly.
                        state   <= ST_CRCB;
                        crc_reg <= CRC32_INIT;
                        idx     <= '0;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= ST_HUNT;
                     end
                  end
                  ST_PAYLOAD: begin
                     if (!dk && len != LW'(MAX_LEN)) begin
                        crc_reg <= crc32_byte(crc_reg, dbyte);
                        len     <= len + 1'b1;
                        pushout <= 1'b1;
                        dataout <= dbyte;
                     end else if (sym == K23_7) begin
                        state <= ST_CRCB;
                        idx   <= '0;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= ST_HUNT;
                     end
                  end
                  ST_CRCB: begin
                     if (!dk) begin
                        rx_crc[{idx, 3'b000} +: 8] <= dbyte;
                        idx <= idx + 1'b1;
                        if (idx == 2'd3) state <= ST_WAIT_EOP;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= ST_HUNT;
                     end
                  end
                  ST_WAIT_EOP: begin
                     if (sym == K28_5) begin
                        eop    <= 1'b1;
                        crc_ok <= (rx_crc == ~crc_reg);
                     end else begin
                        frame_err <= 1'b1;
                     end
                     state <= ST_HUNT;
                  end
                  default: state <= ST_HUNT;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_pkt_rx_10b.sv
// Randomized and directed bench for pkt_rx_10b: packets are encoded here and
// expected bytes/events come from packet-level framing and CRC rules.
module tb_pkt_rx_10b;

   localparam int MAXL  = 16;
   localparam int NSYNC = 4;

   localparam logic [9:0] K28_1N = 10'b0011111001;
   localparam logic [9:0] K28_5N = 10'b0011111010;
   localparam logic [9:0] K23_7N = 10'b1110101000;

   localparam logic [5:0] T6 [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   localparam logic [3:0] T4 [8] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

   logic       clk = 1'b0;
   logic       reset, pushin;
   logic [9:0] datain;
   logic       pushout, startout, eop, crc_ok, frame_err, code_err, disp_err;
   logic [7:0] dataout;

   logic       rd_tb;
   bit         gaps;
   logic [8:0] exp_b[$], obs_b[$];
   logic [3:0] exp_e[$], obs_e[$];
   int         exp_code, obs_code, exp_disp, obs_disp;
   int         n_checks, n_pass;

   pkt_rx_10b #(.MAX_LEN(MAXL), .SYNC_CNT(NSYNC)) dut (
      .clk       (clk),
      .reset     (reset),
      .pushin    (pushin),
      .datain    (datain),
      .pushout   (pushout),
      .dataout   (dataout),
      .startout  (startout),
      .eop       (eop),
      .crc_ok    (crc_ok),
      .frame_err (frame_err),
      .code_err  (code_err),
      .disp_err  (disp_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (pushout) obs_b.push_back({startout, dataout});
         if (eop || frame_err) obs_e.push_back({code_err, frame_err, eop, crc_ok});
         if (code_err) obs_code++;
         if (disp_err) obs_disp++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] outs();
      return 32'({pushout, dataout, startout, eop, crc_ok, frame_err, code_err, disp_err});
   endfunction

   function automatic logic [31:0] crc32_model(input logic [7:0] p[$]);
      logic [31:0] r = 32'hFFFFFFFF;
      foreach (p[i])
         for (int b = 0; b < 8; b++) begin
            logic fb;
            fb = r[0] ^ p[i][b];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
         end
      return ~r;
   endfunction

   task automatic put_sym(input logic [9:0] s);
      @(negedge clk);
      pushin = 1'b1;
      datain = s;
      if (gaps) begin
         int n = $urandom_range(0, 2);
         repeat (n) begin
            @(negedge clk);
            pushin = 1'b0;
         end
      end
   endtask

   task automatic update_rd(input logic [9:0] s);
      int n = $countones(s);
      if (n > 5) rd_tb = 1'b1;
      else if (n < 5) rd_tb = 1'b0;
   endtask

   task automatic send_k(input logic [9:0] neg_form);
      logic [9:0] s = rd_tb ? ~neg_form : neg_form;
      put_sym(s);
      update_rd(s);
   endtask

   task automatic send_data(input logic [7:0] b);
      logic [5:0] c6;
      logic [3:0] c4;
      logic       rdm;
      int         x, y;
      x  = int'(b[4:0]);
      y  = int'(b[7:5]);
      c6 = T6[x];
      if (rd_tb && ($countones(c6) != 3 || x == 7)) c6 = ~c6;
      rdm = ($countones(c6) > 3) ? 1'b1 : ($countones(c6) < 3) ? 1'b0 : rd_tb;
      if (y == 7 && ((!rdm && (x == 17 || x == 18 || x == 20)) ||
                     ( rdm && (x == 11 || x == 13 || x == 14))))
         c4 = 4'b0111;
      else
         c4 = T4[y];
      if (rdm && ($countones(c4) != 2 || y == 3)) c4 = ~c4;
      put_sym({c6, c4});
      update_rd({c6, c4});
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      pushin = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic run_packet(input logic [7:0] p[$], input int nsync,
                             input logic [31:0] crc_sent, input logic exp_ok);
      for (int i = 0; i < nsync; i++) send_k(K28_1N);
      foreach (p[i]) send_data(p[i]);
      send_k(K23_7N);
      for (int i = 0; i < 4; i++) send_data(crc_sent[8*i +: 8]);
      send_k(K28_5N);
      if (nsync < NSYNC) begin
         exp_e.push_back(4'b0100);
      end else if (p.size() > MAXL) begin
         for (int i = 0; i < MAXL; i++) exp_b.push_back({i == 0, p[i]});
         exp_e.push_back(4'b0100);
      end else begin
         foreach (p[i]) exp_b.push_back({i == 0, p[i]});
         exp_e.push_back({3'b001, exp_ok});
      end
   endtask

   task automatic check_scn(input string tag);
      idle(4);
      check({tag, "/nbytes"}, 32'(obs_b.size()), 32'(exp_b.size()));
      for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++)
         check({tag, "/byte"}, 32'(obs_b[i]), 32'(exp_b[i]));
      check({tag, "/nevents"}, 32'(obs_e.size()), 32'(exp_e.size()));
      for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++)
         check({tag, "/event"}, 32'(obs_e[i]), 32'(exp_e[i]));
      check({tag, "/code_err"}, 32'(obs_code), 32'(exp_code));
      check({tag, "/disp_err"}, 32'(obs_disp), 32'(exp_disp));
      obs_b.delete(); exp_b.delete(); obs_e.delete(); exp_e.delete();
      obs_code = 0; exp_code = 0; obs_disp = 0; exp_disp = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0]  p[$], digits[$];
      logic [31:0] crc;
      n_checks = 0; n_pass = 0;
      exp_code = 0; obs_code = 0; exp_disp = 0; obs_disp = 0;
      reset = 1'b0; pushin = 1'b0; datain = '0; gaps = 1'b0; rd_tb = 1'b0;
      for (int i = 0; i < 9; i++) digits.push_back(8'h31 + 8'(i));

      repeat (3) @(negedge clk);
      #1 check("reset_outputs", outs(), 32'h0);
      @(negedge clk) reset = 1'b1;

      // K.28.1 in the RD+ form while RD is negative, then K.28.5 inside SYNC
      put_sym(~K28_1N);
      update_rd(~K28_1N);
      send_k(K28_5N);
      exp_disp = 1;
      exp_e.push_back(4'b0100);
      check_scn("disparity");

      for (int pass = 0; pass < 2; pass++) begin
         gaps = (pass == 1);

         run_packet(digits, 4, 32'hCBF43926, 1'b1);
         check_scn("good_123456789");

         p.delete();
         run_packet(p, 4, 32'h0, 1'b1);
         check_scn("empty");

         run_packet(digits, 4, 32'hCAF43926, 1'b0);
         check_scn("bad_crc");

         run_packet(digits, 3, 32'hCBF43926, 1'b1);
         run_packet(digits, 4, 32'hCBF43926, 1'b1);
         check_scn("short_sync");

         for (int i = 0; i < 4; i++) send_k(K28_1N);
         for (int i = 0; i < 3; i++) send_data(digits[i]);
         put_sym(10'b0000000000);
         for (int i = 0; i < 3; i++) exp_b.push_back({i == 0, digits[i]});
         exp_e.push_back(4'b1100);
         exp_code = 1;
         run_packet(digits, 4, 32'hCBF43926, 1'b1);
         check_scn("illegal_symbol");

         for (int i = 0; i < 4; i++) send_k(K28_1N);
         for (int i = 0; i < 5; i++) begin
            send_data(digits[i]);
            exp_b.push_back({i == 0, digits[i]});
         end
         @(negedge clk);
         pushin = 1'b0;
         #2 reset = 1'b0;
         #1 check("async_reset_outputs", outs(), 32'h0);
         @(negedge clk) reset = 1'b1;
         rd_tb = 1'b0;
         run_packet(digits, 4, 32'hCBF43926, 1'b1);
         check_scn("reset_mid_packet");

         for (int n = MAXL; n <= MAXL + 1; n++) begin
            p.delete();
            for (int i = 0; i < n; i++) p.push_back(8'($urandom));
            run_packet(p, 5, crc32_model(p), 1'b1);
         end
         check_scn("max_len");
      end

      for (int t = 0; t < 40; t++) begin
         int n;
         gaps = ($urandom_range(0, 1) == 1);
         n = $urandom_range(0, MAXL + 2);
         p.delete();
         for (int i = 0; i < n; i++) p.push_back(8'($urandom));
         crc = crc32_model(p);
         if ($urandom_range(0, 3) == 0) crc = crc ^ (32'h1 << $urandom_range(0, 31));
         run_packet(p, $urandom_range(3, 6), crc, crc == crc32_model(p));
         check_scn("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
